// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Widths and latencies shared by the functional units, the
//               issuer and the result collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int WORD_W       = 64;
    localparam int FU_LATENCY   = 7;
    localparam int TAG_W        = 5;
    localparam int RESULT_DEPTH = 8;

endpackage

`default_nettype wire

// File: rtl/result_fifo.sv
// ============================================================================
// Module      : result_fifo
// Description : Synchronous FIFO with wrapping pointers and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo #(
    parameter int W     = 69,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    // A write into a full FIFO is dropped unless the same edge frees the head.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_result_collector.sv
// ============================================================================
// Module      : alu_result_collector
// Description : Tags FU operations, tracks them to the FU output and queues
//               results for writeback under credit flow control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_collector #(
    parameter int WIDTH   = cpu_pkg::WORD_W,
    parameter int LATENCY = cpu_pkg::FU_LATENCY,
    parameter int TAG_W   = cpu_pkg::TAG_W,
    parameter int DEPTH   = cpu_pkg::RESULT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    input  logic [WIDTH-1:0] fu_result,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic [WIDTH-1:0] wb_data,
    input  logic             wb_ready,
    output logic             err
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic                     r_tok_v   [LATENCY];
    logic [TAG_W-1:0]         r_tok_tag [LATENCY];
    logic [c_cnt_w-1:0]       r_cred;
    logic                     r_err;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic [c_cnt_w-1:0]       w_count;
    logic [TAG_W+WIDTH-1:0]   w_head;

    assign w_pop       = wb_ready & (w_count != '0);
    // A pop in this cycle returns a credit early enough to cover this accept.
    assign issue_ready = (r_cred != '0) | w_pop;
    assign w_accept    = issue_valid & issue_ready;
    assign w_push      = r_tok_v[LATENCY-1];
    assign wb_valid    = ~w_empty;
    assign {wb_tag, wb_data} = w_head;
    assign err         = r_err;

    for (genvar i = 0; i < LATENCY; i++) begin : g_tok
        if (i == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tok_v[i]   <= 1'b0;
                    r_tok_tag[i] <= '0;
                end else begin
                    r_tok_v[i]   <= w_accept;
                    r_tok_tag[i] <= issue_tag;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tok_v[i]   <= 1'b0;
                    r_tok_tag[i] <= '0;
                end else begin
                    r_tok_v[i]   <= r_tok_v[i-1];
                    r_tok_tag[i] <= r_tok_tag[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cred <= c_cnt_w'(DEPTH);
            r_err  <= 1'b0;
        end else begin
            if (w_accept && !w_pop) begin
                r_cred <= r_cred - c_cnt_w'(1);
            end else if (w_pop && !w_accept) begin
                r_cred <= r_cred + c_cnt_w'(1);
            end
            if (w_push && w_full && !w_pop) begin
                r_err <= 1'b1;
            end
        end
    end

    result_fifo #(
        .W     (TAG_W + WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (c_cnt_w)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   ({r_tok_tag[LATENCY-1], fu_result}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_alu_result_collector.sv
// ============================================================================
// Module      : tb_alu_result_collector
// Description : Self-checking bench; an AND-type FU model feeds the collector
//               and a queue of outstanding ops predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_collector;

    localparam int W  = 64;
    localparam int L  = 7;
    localparam int TW = 5;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [TW-1:0] issue_tag;
    logic          issue_ready;
    logic [W-1:0]  fu_result;
    logic          wb_valid;
    logic [TW-1:0] wb_tag;
    logic [W-1:0]  wb_data;
    logic          wb_ready;
    logic          err;

    logic [W-1:0]  fa;
    logic [W-1:0]  fb;
    logic [W-1:0]  fu_pipe [L];

    typedef struct {
        logic [TW-1:0] tag;
        logic [W-1:0]  data;
        int            rdy;
    } ent_t;

    ent_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    alu_result_collector dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .fu_result   (fu_result),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Functional unit: a & b, seven registered stages, cannot stall.
    always @(posedge clk) begin
        fu_pipe[0] <= fa & fb;
        for (int i = 1; i < L; i++) fu_pipe[i] <= fu_pipe[i-1];
    end
    assign fu_result = fu_pipe[L-1];

    // One cycle: drive inputs, compare outputs with the outstanding-op queue,
    // then advance the model. An op issued in cycle n is visible from n+L+1.
    task automatic drive_cycle(input bit iv, input logic [TW-1:0] tag,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit wr, input bit do_rst,
                               output bit acc, output bit vld,
                               output logic [TW-1:0] otag, output logic [W-1:0] odata,
                               output bit ordy);
        bit exp_v;
        bit exp_pop;
        bit exp_rdy;
        @(negedge clk);
        rst         = do_rst;
        issue_valid = iv & ~do_rst;
        issue_tag   = tag;
        fa          = a;
        fb          = b;
        wb_ready    = wr;
        #1;
        if (do_rst) q.delete();
        exp_v   = (q.size() > 0) && (q[0].rdy <= cyc);
        exp_pop = exp_v & wr;
        exp_rdy = (q.size() < D) || exp_pop;
        checks++;
        if (wb_valid !== exp_v) begin
            errors++;
            $display("FAIL wb_valid cyc=%0d: got %b expected %b", cyc, wb_valid, exp_v);
        end
        if (exp_v) begin
            checks++;
            if (wb_tag !== q[0].tag || wb_data !== q[0].data) begin
                errors++;
                $display("FAIL wb_head cyc=%0d: got tag %0h data %0h expected tag %0h data %0h",
                         cyc, wb_tag, wb_data, q[0].tag, q[0].data);
            end
        end
        checks++;
        if (issue_ready !== exp_rdy) begin
            errors++;
            $display("FAIL issue_ready cyc=%0d: got %b expected %b", cyc, issue_ready, exp_rdy);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err cyc=%0d: got %b expected 0", cyc, err);
        end
        vld   = wb_valid;
        otag  = wb_tag;
        odata = wb_data;
        ordy  = issue_ready;
        acc   = issue_valid & exp_rdy;
        if (exp_pop) void'(q.pop_front());
        if (acc) q.push_back('{tag, a & b, cyc + L + 1});
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; issue_valid = 1'b0; issue_tag = '0; wb_ready = 1'b0;
        fa = '0; fb = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready);
        end
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", err);
        end
    endtask

    task automatic test_single_op();
        bit acc, v, r; logic [TW-1:0] t; logic [W-1:0] d;
        for (int k = 0; k < 12; k++) begin
            drive_cycle(k == 0, 5'd3, 64'h444F, 64'hFFFE, 1'b1, 1'b0, acc, v, t, d, r);
            checks++;
            if (v !== (k == 8)) begin
                errors++; $display("FAIL single_valid k=%0d: got %b expected %b", k, v, (k == 8));
            end
            if (k == 8) begin
                checks++;
                if (t !== 5'd3 || d !== 64'h444E) begin
                    errors++; $display("FAIL single_result: got tag %0h data %0h expected tag 3 data 444e", t, d);
                end
            end
        end
    endtask

    task automatic test_streaming();
        bit acc, v, r; logic [TW-1:0] t; logic [W-1:0] d;
        for (int k = 0; k < 26; k++) begin
            drive_cycle(k < 16, TW'(k), {$urandom, $urandom}, {$urandom, $urandom},
                        1'b1, 1'b0, acc, v, t, d, r);
            if (k < 16) begin
                checks++;
                if (r !== 1'b1) begin
                    errors++; $display("FAIL stream_ready k=%0d: got %b expected 1", k, r);
                end
            end
            if (k >= 8 && k < 24) begin
                checks++;
                if (v !== 1'b1 || t !== TW'(k - 8)) begin
                    errors++; $display("FAIL stream_order k=%0d: got valid %b tag %0d expected valid 1 tag %0d", k, v, t, k - 8);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc, v, r; logic [TW-1:0] t; logic [W-1:0] d;
        int n_acc = 0;
        for (int k = 0; k < 16; k++) begin
            drive_cycle(1'b1, TW'(k), {$urandom, $urandom}, {$urandom, $urandom},
                        1'b0, 1'b0, acc, v, t, d, r);
            if (acc) n_acc++;
            if (k >= 8) begin
                checks++;
                if (r !== 1'b0) begin
                    errors++; $display("FAIL bp_ready_low k=%0d: got %b expected 0", k, r);
                end
            end
        end
        checks++;
        if (n_acc != 8) begin
            errors++; $display("FAIL bp_accepts: got %0d expected 8", n_acc);
        end
        for (int k = 0; k < 10; k++) begin
            drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc, v, t, d, r);
            if (k == 0) begin
                checks++;
                if (r !== 1'b1) begin
                    errors++; $display("FAIL bp_ready_on_pop: got %b expected 1", r);
                end
            end
            checks++;
            if (v !== (k < 8) || (k < 8 && t !== TW'(k))) begin
                errors++; $display("FAIL bp_drain k=%0d: got valid %b tag %0d expected valid %b tag %0d", k, v, t, (k < 8), k);
            end
        end
    endtask

    task automatic test_credit_boundary();
        bit acc, v, r; logic [TW-1:0] t; logic [W-1:0] d;
        for (int k = 0; k < 16; k++)
            drive_cycle(1'b1, TW'(20 + k), {$urandom, $urandom}, {$urandom, $urandom},
                        1'b0, 1'b0, acc, v, t, d, r);
        drive_cycle(1'b1, 5'd31, {$urandom, $urandom}, {$urandom, $urandom},
                    1'b1, 1'b0, acc, v, t, d, r);
        checks++;
        if (acc !== 1'b1 || r !== 1'b1 || v !== 1'b1) begin
            errors++; $display("FAIL credit_accept: got ready %b valid %b expected 1 1", r, v);
        end
        drive_cycle(1'b1, 5'd30, '0, '0, 1'b0, 1'b0, acc, v, t, d, r);
        checks++;
        if (r !== 1'b0) begin
            errors++; $display("FAIL credit_still_zero: got ready %b expected 0", r);
        end
        for (int k = 0; k < 20; k++)
            drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc, v, t, d, r);
    endtask

    task automatic test_reset_midflight();
        bit acc, v, r; logic [TW-1:0] t; logic [W-1:0] d;
        for (int k = 0; k < 5; k++)
            drive_cycle(k < 3, TW'(10 + k), {$urandom, $urandom}, {$urandom, $urandom},
                        1'b1, k == 4, acc, v, t, d, r);
        for (int k = 0; k < 12; k++) begin
            drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc, v, t, d, r);
            checks++;
            if (v !== 1'b0 || r !== 1'b1) begin
                errors++; $display("FAIL midreset_quiet k=%0d: got valid %b ready %b expected 0 1", k, v, r);
            end
        end
        for (int k = 0; k < 12; k++) begin
            drive_cycle(k == 0, 5'd9, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_FFFF_0000,
                        1'b1, 1'b0, acc, v, t, d, r);
            checks++;
            if (v !== (k == 8) || (k == 8 && (t !== 5'd9 || d !== 64'hDEAD_0000_0123_0000))) begin
                errors++; $display("FAIL midreset_reissue k=%0d: got valid %b tag %0d data %0h", k, v, t, d);
            end
        end
    endtask

    task automatic test_random();
        bit acc, v, r; logic [TW-1:0] t; logic [W-1:0] d;
        for (int k = 0; k < 10000; k++)
            drive_cycle(($urandom % 10) < 6, TW'($urandom), {$urandom, $urandom},
                        {$urandom, $urandom}, ($urandom % 10) < 7, 1'b0, acc, v, t, d, r);
        for (int k = 0; k < 40; k++)
            drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, acc, v, t, d, r);
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL random_drain: got %0d outstanding expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_streaming();
        test_backpressure();
        test_credit_boundary();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
